// File: rtl/cpu_clk_ctrl.sv
`default_nettype none
// ==========================================================================
// cpu_clk_ctrl: CPU clock-enable generator with free-run, single-step, halt.
// Revision: 1.0
// ==========================================================================
module cpu_clk_ctrl #(
  parameter int DB_CYCLES = 16,
  parameter int RUN_DIV   = 2
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        run_i,
  input  logic        step_btn_i,
  input  logic        halt_i,
  output logic        cpu_ce_o,
  output logic [31:0] cycle_cnt_o,
  output logic [1:0]  state_o,
  output logic        halted_o
);

  localparam logic [1:0] ST_STEP = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_HALT = 2'b11;

  localparam int DB_W  = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam int DIV_W = (RUN_DIV > 1) ? $clog2(RUN_DIV) : 1;
  localparam logic [DB_W-1:0]  DB_LAST  = DB_W'(DB_CYCLES - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RUN_DIV - 1);

  logic             run_meta, run_sync;
  logic             btn_meta, btn_sync;
  logic             db_level, db_prev;
  logic [DB_W-1:0]  db_cnt;
  logic             step_req;
  logic [1:0]       state, state_nxt;
  logic [DIV_W-1:0] div_cnt;
  logic             ce_nxt;
  logic             cpu_ce;
  logic [31:0]      cycle_cnt;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      run_meta <= 1'b0;
      run_sync <= 1'b0;
      btn_meta <= 1'b0;
      btn_sync <= 1'b0;
    end else begin
      run_meta <= run_i;
      run_sync <= run_meta;
      btn_meta <= step_btn_i;
      btn_sync <= btn_meta;
    end
  end

  // Level flips on the DB_CYCLES-th consecutive differing cycle; a match restarts.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      db_level <= 1'b0;
      db_prev  <= 1'b0;
      db_cnt   <= '0;
    end else begin
      db_prev <= db_level;
      if (btn_sync == db_level) begin
        db_cnt <= '0;
      end else if (db_cnt == DB_LAST) begin
        db_level <= btn_sync;
        db_cnt   <= '0;
      end else begin
        db_cnt <= db_cnt + DB_W'(1);
      end
    end
  end

  assign step_req = db_level & ~db_prev;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_STEP;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_STEP: begin
        if (halt_i)        state_nxt = ST_HALT;
        else if (run_sync) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (halt_i)         state_nxt = ST_HALT;
        else if (!run_sync) state_nxt = ST_STEP;
      end
      ST_HALT: begin
        if (!halt_i && step_req && !run_sync) state_nxt = ST_STEP;
      end
      default: state_nxt = ST_STEP;
    endcase
  end

  // Leaving RUN (to STEP or HALT) drops the divider's pending pulse.
  always_comb begin
    ce_nxt = 1'b0;
    case (state)
      ST_STEP: ce_nxt = !halt_i && step_req;
      ST_RUN:  ce_nxt = !halt_i && run_sync && (div_cnt == DIV_LAST);
      default: ce_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      div_cnt   <= '0;
      cpu_ce    <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (state == ST_RUN && state_nxt == ST_RUN)
        div_cnt <= (div_cnt == DIV_LAST) ? '0 : div_cnt + DIV_W'(1);
      else
        div_cnt <= '0;
      cpu_ce    <= ce_nxt;
      cycle_cnt <= cycle_cnt + 32'(ce_nxt);
    end
  end

  assign cpu_ce_o    = cpu_ce;
  assign cycle_cnt_o = cycle_cnt;
  assign state_o     = state;
  assign halted_o    = (state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_clk_ctrl.sv
`default_nettype none
`timescale 1ns/1ps
// ==========================================================================
// tb_cpu_clk_ctrl: directed self-checking bench for cpu_clk_ctrl.
// Revision: 1.0
// ==========================================================================
module tb_cpu_clk_ctrl;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        run = 1'b0;
  logic        step_btn = 1'b0;
  logic        halt = 1'b0;
  logic        ce, ce1;
  logic [31:0] cnt, cnt1;
  logic [1:0]  st, st1;
  logic        hlt, hlt1;

  int tests  = 0;
  int failed = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  cpu_clk_ctrl #(.DB_CYCLES(4), .RUN_DIV(3)) dut (
    .clk_i(clk), .rst_i(rst_i), .run_i(run), .step_btn_i(step_btn), .halt_i(halt),
    .cpu_ce_o(ce), .cycle_cnt_o(cnt), .state_o(st), .halted_o(hlt)
  );

  cpu_clk_ctrl #(.DB_CYCLES(2), .RUN_DIV(1)) dut1 (
    .clk_i(clk), .rst_i(rst_i), .run_i(run), .step_btn_i(step_btn), .halt_i(halt),
    .cpu_ce_o(ce1), .cycle_cnt_o(cnt1), .state_o(st1), .halted_o(hlt1)
  );

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (ce) pulses++;
    end
  endtask

  task automatic test_reset();
    #2 rst_i = 1'b1;
    #1;
    tests++;
    if (ce !== 1'b0 || cnt !== 32'd0 || st !== 2'b00 || hlt !== 1'b0) begin
      failed++;
      $display("FAIL reset_async: ce=%b cnt=%h state=%b halted=%b, expected 0/00000000/00/0", ce, cnt, st, hlt);
    end
    repeat (3) @(negedge clk);
    tests++;
    if (ce !== 1'b0 || cnt !== 32'd0 || st !== 2'b00 || hlt !== 1'b0 || st1 !== 2'b00 || cnt1 !== 32'd0) begin
      failed++;
      $display("FAIL reset_held: ce=%b cnt=%h state=%b halted=%b state1=%b cnt1=%h, expected all zero", ce, cnt, st, hlt, st1, cnt1);
    end
    rst_i = 1'b0;
    run_cycles(3);
  endtask

  task automatic test_step();
    int p0;
    int first;
    p0 = pulses;
    first = -1;
    step_btn = 1'b1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (ce) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    tests++;
    if (pulses - p0 !== 1) begin
      failed++;
      $display("FAIL step_pulses: got %0d pulses, expected 1", pulses - p0);
    end
    tests++;
    if (first !== 7) begin
      failed++;
      $display("FAIL step_latency: pulse seen %0d cycles after press, expected 7", first);
    end
    tests++;
    if (cnt !== 32'd1 || st !== 2'b00) begin
      failed++;
      $display("FAIL step_state: cnt=%h state=%b, expected 00000001/00", cnt, st);
    end
    step_btn = 1'b0;
    run_cycles(12);
    tests++;
    if (pulses - p0 !== 1) begin
      failed++;
      $display("FAIL step_release: got %0d pulses, expected 1 (release must not pulse)", pulses - p0);
    end
  endtask

  task automatic test_bounce();
    int p0;
    p0 = pulses;
    for (int i = 0; i < 15; i++) begin
      step_btn = ~step_btn;
      run_cycles(2);
    end
    tests++;
    if (pulses - p0 !== 0) begin
      failed++;
      $display("FAIL bounce_quiet: got %0d pulses during bounce, expected 0", pulses - p0);
    end
    run_cycles(20);
    tests++;
    if (pulses - p0 !== 1 || cnt !== 32'd2) begin
      failed++;
      $display("FAIL bounce_settle: got %0d pulses cnt=%h, expected 1 pulse cnt=00000002", pulses - p0, cnt);
    end
    step_btn = 1'b0;
    run_cycles(12);
  endtask

  task automatic test_run();
    logic [31:0] c0;
    logic        exp;
    bit          found;
    c0 = cnt;
    found = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge clk);
      if (st === 2'b01) found = 1'b1;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL run_entry: state=%b, expected 01 within 10 cycles", st);
    end
    for (int j = 0; j < 30; j++) begin
      if (j > 0) @(negedge clk);
      exp = (j > 0) && (j % 3 == 0);
      tests++;
      if (ce !== exp) begin
        failed++;
        $display("FAIL run_ce[%0d]: ce=%b, expected %b", j, ce, exp);
      end
      tests++;
      if (ce1 !== (j > 0)) begin
        failed++;
        $display("FAIL run_div1_ce[%0d]: ce=%b, expected %b", j, ce1, (j > 0));
      end
      if (j == 5)  step_btn = 1'b1;
      if (j == 17) step_btn = 1'b0;
    end
    tests++;
    if (cnt !== c0 + 32'd9) begin
      failed++;
      $display("FAIL run_count: cnt=%h, expected %h", cnt, c0 + 32'd9);
    end
  endtask

  task automatic test_halt();
    int p0;
    logic [31:0] c0;
    repeat (3) @(negedge clk);
    halt = 1'b1;
    @(negedge clk);
    halt = 1'b0;
    tests++;
    if (ce !== 1'b0 || st !== 2'b11 || hlt !== 1'b1) begin
      failed++;
      $display("FAIL halt_entry: ce=%b state=%b halted=%b, expected 0/11/1", ce, st, hlt);
    end
    tests++;
    if (ce1 !== 1'b0 || hlt1 !== 1'b1) begin
      failed++;
      $display("FAIL halt_div1: ce=%b halted=%b, expected 0/1", ce1, hlt1);
    end
    p0 = pulses;
    c0 = cnt;
    step_btn = 1'b1;
    run_cycles(12);
    step_btn = 1'b0;
    run_cycles(12);
    tests++;
    if (st !== 2'b11 || pulses - p0 !== 0) begin
      failed++;
      $display("FAIL halt_hold: state=%b pulses=%0d, expected 11/0", st, pulses - p0);
    end
    run = 1'b0;
    run_cycles(4);
    step_btn = 1'b1;
    run_cycles(12);
    tests++;
    if (st !== 2'b00 || hlt !== 1'b0 || pulses - p0 !== 0 || cnt !== c0) begin
      failed++;
      $display("FAIL halt_exit: state=%b halted=%b pulses=%0d cnt=%h, expected 00/0/0/%h", st, hlt, pulses - p0, cnt, c0);
    end
    step_btn = 1'b0;
    run_cycles(12);
  endtask

  task automatic test_wrap();
    int p0;
    force dut.cycle_cnt = 32'hFFFF_FFFF;
    @(negedge clk);
    @(negedge clk);
    release dut.cycle_cnt;
    #1;
    tests++;
    if (cnt !== 32'hFFFF_FFFF) begin
      failed++;
      $display("FAIL wrap_preload: cnt=%h, expected ffffffff", cnt);
    end
    p0 = pulses;
    step_btn = 1'b1;
    run_cycles(20);
    tests++;
    if (cnt !== 32'd0 || pulses - p0 !== 1) begin
      failed++;
      $display("FAIL wrap: cnt=%h pulses=%0d, expected 00000000/1", cnt, pulses - p0);
    end
    step_btn = 1'b0;
    run_cycles(12);
  endtask

  task automatic test_reset_mid_run();
    int  p0;
    bit  found;
    found = 1'b0;
    run = 1'b1;
    for (int k = 0; k < 20 && !found; k++) begin
      @(negedge clk);
      if (ce === 1'b1) found = 1'b1;
    end
    tests++;
    if (!found) begin
      failed++;
      $display("FAIL midrun_pulse: ce=%b state=%b, expected a run pulse within 20 cycles", ce, st);
    end
    #2 rst_i = 1'b1;
    #1;
    tests++;
    if (ce !== 1'b0 || cnt !== 32'd0 || st !== 2'b00 || hlt !== 1'b0) begin
      failed++;
      $display("FAIL midrun_reset: ce=%b cnt=%h state=%b halted=%b, expected 0/00000000/00/0", ce, cnt, st, hlt);
    end
    step_btn = 1'b1;
    run = 1'b0;
    @(negedge clk);
    rst_i = 1'b0;
    p0 = pulses;
    run_cycles(5);
    tests++;
    if (pulses - p0 !== 0) begin
      failed++;
      $display("FAIL post_reset_debounce: got %0d early pulses, expected 0", pulses - p0);
    end
    run_cycles(15);
    tests++;
    if (pulses - p0 !== 1 || cnt !== 32'd1 || st !== 2'b00) begin
      failed++;
      $display("FAIL post_reset_step: pulses=%0d cnt=%h state=%b, expected 1/00000001/00", pulses - p0, cnt, st);
    end
    step_btn = 1'b0;
    run_cycles(5);
  endtask

  initial begin
    test_reset();
    test_step();
    test_bounce();
    test_run();
    test_halt();
    test_wrap();
    test_reset_mid_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
